spi_flash_arbiter: RTL and testbench

- Shares the chip's single SPI master pins (ss, spi_clk, mosi, miso) between two requesters: instruction fetch (port 0) and load/store data (port 1).
- Each granted request becomes one complete SPI READ transaction: command, 24-bit address, then 32 data bits.
- Sits inside chip between the core's memory interfaces and the SPI pins routed through chip_io.
- SPI mode 0 only. Read-only.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_flash_arbiter_if.sv | 30 +++
 rtl/spi_shift_engine.sv | 94 +++++++++
 rtl/spi_flash_arbiter.sv | 125 ++++++++++++
 tb/tb_spi_flash_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int         SPI_FRAME_BITS   = 64;
    localparam int         SPI_DATA_BITS    = 32;
    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

    // Command, word-aligned address, then zeros so mosi idles low during data.
    function automatic logic [SPI_FRAME_BITS-1:0] read_frame(input logic [7:0]  cmd,
                                                             input logic [23:0] addr);
        return {cmd, addr & ~24'h3, {SPI_DATA_BITS{1'b0}}};
    endfunction

    // First received byte lands in the least significant byte.
    function automatic logic [SPI_DATA_BITS-1:0] byte_swap32(input logic [SPI_DATA_BITS-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Requester handshakes and SPI pins of the flash arbiter.
interface spi_flash_arbiter_if;

    logic        if_req;
    logic [23:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [23:0] d_addr;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        busy;
    logic        ss;
    logic        spi_clk;
    logic        mosi;
    logic        miso;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_addr, miso,
        output if_ack, if_rdata, d_ack, d_rdata, busy, ss, spi_clk, mosi
    );

    // Requester / pad side.
    modport master (
        output if_req, if_addr, d_req, d_addr, miso,
        input  if_ack, if_rdata, d_ack, d_rdata, busy, ss, spi_clk, mosi
    );

endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 frame engine: clock divider, 64-bit transmit shifter, receive
// sampler and a done pulse in the last cycle of the frame.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SPI_FRAME_BITS-1:0] frame,
    input  logic                      miso,
    output logic                      spi_clk,
    output logic                      mosi,
    output logic [SPI_DATA_BITS-1:0]  rx_data,
    output logic                      done
);

    localparam int          DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int          HALF_W    = $clog2(2 * SPI_FRAME_BITS);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * SPI_FRAME_BITS - 1);

    logic                      active_q,   active_d;
    logic [DIV_W-1:0]          div_cnt_q,  div_cnt_d;
    logic [HALF_W-1:0]         half_cnt_q, half_cnt_d;
    logic                      sck_q,      sck_d;
    logic [SPI_FRAME_BITS-1:0] tx_q,       tx_d;
    logic [SPI_DATA_BITS-1:0]  rx_q,       rx_d;
    logic                      div_wrap;

    // Next-state: each divider wrap toggles spi_clk; rising half samples, falling half shifts.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        active_d   = active_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        sck_d      = sck_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        done       = 1'b0;
        div_wrap   = (div_cnt_q == DIV_W'(CLK_DIV - 1));

        if (start) begin
            active_d   = 1'b1;
            div_cnt_d  = '0;
            half_cnt_d = '0;
            sck_d      = 1'b0;
            tx_d       = frame;
        end else if (active_q) begin
            if (div_wrap) begin
                div_cnt_d  = '0;
                sck_d      = ~sck_q;
                half_cnt_d = half_cnt_q + 1'b1;
                if (!sck_q) begin
                    rx_d = {rx_q[SPI_DATA_BITS-2:0], miso};
                end else begin
                    tx_d = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
                end
                if (half_cnt_q == HALF_LAST) begin
                    active_d = 1'b0;
                    done     = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the shift registers are reset too; they are small and this keeps mosi at 0 out of reset.
        if (reset) begin
            active_q   <= 1'b0;
            div_cnt_q  <= '0;
            half_cnt_q <= '0;
            sck_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            active_q   <= active_d;
            div_cnt_q  <= div_cnt_d;
            half_cnt_q <= half_cnt_d;
            sck_q      <= sck_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    assign spi_clk = sck_q;
    assign mosi    = tx_q[SPI_FRAME_BITS-1];
    assign rx_data = rx_q;

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin arbiter turning fetch/data requests into SPI READ frames.
module spi_flash_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter logic [7:0]  READ_CMD = READ_CMD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    spi_flash_arbiter_if.slave  bus
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_e                   state_q,      state_d;
    logic                     last_grant_q, last_grant_d;
    logic [GAP_W-1:0]         gap_cnt_q,    gap_cnt_d;
    logic                     ss_q,         ss_d;
    logic                     if_ack_q,     if_ack_d;
    logic                     d_ack_q,      d_ack_d;
    logic [SPI_DATA_BITS-1:0] if_rdata_q,   if_rdata_d;
    logic [SPI_DATA_BITS-1:0] d_rdata_q,    d_rdata_d;

    logic                      start;
    logic                      gnt_port;
    logic [SPI_FRAME_BITS-1:0] frame;
    logic [SPI_DATA_BITS-1:0]  rx_data;
    logic                      eng_done;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .frame   (frame),
        .miso    (bus.miso),
        .spi_clk (bus.spi_clk),
        .mosi    (bus.mosi),
        .rx_data (rx_data),
        .done    (eng_done)
    );

    // Arbitration, frame sequencing and ack/rdata steering.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        ss_d         = ss_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        start        = 1'b0;

        // On a tie the port that did not win last time gets the bus.
        gnt_port = (bus.if_req && bus.d_req) ? ~last_grant_q : bus.d_req;
        frame    = read_frame(READ_CMD, gnt_port ? bus.d_addr : bus.if_addr);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    start        = 1'b1;
                    last_grant_d = gnt_port;
                    ss_d         = 1'b0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    ss_d      = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                    if (last_grant_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = byte_swap32(rx_data);
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = byte_swap32(rx_data);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered FSM state and outputs; reset aborts any frame without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gap_cnt_q    <= '0;
            ss_q         <= 1'b1;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            ss_q         <= ss_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.ss       = ss_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench: two arbiters (CLK_DIV=2/CS_GAP=4 and CLK_DIV=1/CS_GAP=1)
// each talking to a mode-0 flash model, with a per-DUT scoreboard of expected acks.
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_flash_arbiter_if bus0 ();
    spi_flash_arbiter_if bus1 ();

    spi_flash_arbiter dut0 (.clk(clk), .reset(reset), .bus(bus0));
    spi_flash_arbiter #(.CLK_DIV(1), .CS_GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- flash model ----------------
    int          fl_n       [2] = '{0, 0};
    logic [31:0] fl_hdr     [2];
    logic [31:0] fl_stream  [2];
    logic        fl_prev_ss [2] = '{1'b1, 1'b1};
    logic        fl_prev_sck[2] = '{1'b0, 1'b0};
    logic        fl_mosi_bad[2] = '{1'b0, 1'b0};
    logic        fl_miso    [2] = '{1'b0, 1'b0};

    // Bytes in transmit order {b0,b1,b2,b3}, keyed by the address the flash received.
    function automatic logic [31:0] flash_stream(input logic [23:0] a);
        if (a == 24'h000104) return 32'h13000000;
        if (a == 24'h000004) return 32'hAABBCCDD;
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'h3C, a[23:16] ^ 8'hA5, 8'h69};
    endfunction

    task automatic flash_step(input int k, input logic ss, input logic sck, input logic mo);
        if (fl_prev_ss[k] === 1'b1 && ss === 1'b0) begin
            fl_n[k] = 0; fl_mosi_bad[k] = 1'b0; fl_miso[k] = 1'b0;
        end
        if (ss === 1'b0) begin
            if (fl_prev_sck[k] === 1'b0 && sck === 1'b1) begin
                if (fl_n[k] < 32) fl_hdr[k] = {fl_hdr[k][30:0], mo};
                else if (mo !== 1'b0) fl_mosi_bad[k] = 1'b1;
                fl_n[k]++;
                if (fl_n[k] == 32) fl_stream[k] = flash_stream(fl_hdr[k][23:0]);
            end else if (fl_prev_sck[k] === 1'b1 && sck === 1'b0) begin
                if (fl_n[k] >= 32 && fl_n[k] < 64) fl_miso[k] = fl_stream[k][63 - fl_n[k]];
            end
        end
        fl_prev_ss[k]  = ss;
        fl_prev_sck[k] = sck;
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int          port;
        logic [31:0] hdr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   acks_seen[2] = '{0, 0};
    int   grant_cyc[2] = '{0, 0};
    logic mon_prev_ss[2] = '{1'b1, 1'b1};
    int   grant_q0[$];
    int   lat[2] = '{257, 129};

    task automatic mon_step(input int k, input logic ss, input logic ia, input logic da,
                            input logic [31:0] ird, input logic [31:0] drd);
        exp_t e;
        logic have;
        if (mon_prev_ss[k] === 1'b1 && ss === 1'b0) begin
            grant_cyc[k] = cyc - 1;
            if (k == 0) grant_q0.push_back(cyc - 1);
        end
        if (ia === 1'b1 || da === 1'b1) begin
            acks_seen[k]++;
            have = 1'b0;
            if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            if (!have) begin
                checks++; errors++;
                $display("FAIL unexpected_ack dut%0d: if_ack=%b d_ack=%b with nothing expected", k, ia, da);
            end else begin
                check($sformatf("ack_port dut%0d", k), 64'({ia, da}), (e.port == 1) ? 64'h1 : 64'h2);
                check($sformatf("rdata dut%0d", k), 64'(da ? drd : ird), 64'(e.rdata));
                check($sformatf("mosi_hdr dut%0d", k), 64'(fl_hdr[k]), 64'(e.hdr));
                check($sformatf("latency dut%0d", k), 64'(cyc - grant_cyc[k]), 64'(lat[k]));
                check($sformatf("mosi_data_zero dut%0d", k), 64'(fl_mosi_bad[k]), 64'h0);
            end
        end
        mon_prev_ss[k] = ss;
    endtask

    always @(negedge clk) begin
        flash_step(0, bus0.ss, bus0.spi_clk, bus0.mosi);
        bus0.miso = fl_miso[0];
        flash_step(1, bus1.ss, bus1.spi_clk, bus1.mosi);
        bus1.miso = fl_miso[1];
        mon_step(0, bus0.ss, bus0.if_ack, bus0.d_ack, bus0.if_rdata, bus0.d_rdata);
        mon_step(1, bus1.ss, bus1.if_ack, bus1.d_ack, bus1.if_rdata, bus1.d_rdata);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic set_req(input int k, input int port, input logic val, input logic [23:0] addr);
        if (k == 0) begin
            if (port == 0) begin bus0.if_req = val; bus0.if_addr = addr; end
            else           begin bus0.d_req  = val; bus0.d_addr  = addr; end
        end else begin
            if (port == 0) begin bus1.if_req = val; bus1.if_addr = addr; end
            else           begin bus1.d_req  = val; bus1.d_addr  = addr; end
        end
    endtask

    task automatic wait_acks(input int k, input int target, input int budget, input string name);
        for (int i = 0; i < budget && acks_seen[k] < target; i++) tick(1);
        check(name, 64'(acks_seen[k] >= target), 64'h1);
    endtask

    typedef struct {
        int          dut;
        int          port;
        logic [23:0] addr;
        logic [31:0] hdr;
        logic [31:0] rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic [31:0] held;
        e.port = v.port; e.hdr = v.hdr; e.rdata = v.rdata;
        if (v.dut == 0) sb0.push_back(e); else sb1.push_back(e);
        set_req(v.dut, v.port, 1'b1, v.addr);
        wait_acks(v.dut, acks_seen[v.dut] + 1, 400, $sformatf("ack_arrives dut%0d port%0d", v.dut, v.port));
        set_req(v.dut, v.port, 1'b0, v.addr);
        tick(3);
        if (v.dut == 0) held = (v.port == 1) ? bus0.d_rdata : bus0.if_rdata;
        else            held = (v.port == 1) ? bus1.d_rdata : bus1.if_rdata;
        check($sformatf("rdata_held dut%0d port%0d", v.dut, v.port), 64'(held), 64'(v.rdata));
    endtask

    // ---------------- test ----------------
    vec_t vecs[5];

    initial begin
        int base;
        int g0;
        exp_t e;

        vecs[0] = '{0, 0, 24'h000104, 32'h03000104, 32'h00000013};
        vecs[1] = '{0, 1, 24'h000007, 32'h03000004, 32'hDDCCBBAA};
        vecs[2] = '{0, 1, 24'hFFFFFF, 32'h03FFFFFC, 32'h695AC3A6};
        vecs[3] = '{0, 0, 24'h12345B, 32'h03123458, 32'h69B70802};
        vecs[4] = '{1, 0, 24'h000104, 32'h03000104, 32'h00000013};

        reset = 1'b1;
        bus0.if_req = 1'b0; bus0.d_req = 1'b0; bus0.if_addr = '0; bus0.d_addr = '0;
        bus1.if_req = 1'b0; bus1.d_req = 1'b0; bus1.if_addr = '0; bus1.d_addr = '0;
        do_reset();

        // Reset state.
        check("rst ss",       64'(bus0.ss),       64'h1);
        check("rst spi_clk",  64'(bus0.spi_clk),  64'h0);
        check("rst mosi",     64'(bus0.mosi),     64'h0);
        check("rst busy",     64'(bus0.busy),     64'h0);
        check("rst if_ack",   64'(bus0.if_ack),   64'h0);
        check("rst d_ack",    64'(bus0.d_ack),    64'h0);
        check("rst if_rdata", 64'(bus0.if_rdata), 64'h0);
        check("rst d_rdata",  64'(bus0.d_rdata),  64'h0);
        check("rst ss dut1",  64'(bus1.ss),       64'h1);

        // Single transactions from the vector table.
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Tie after reset followed by sustained contention: 0,1,0,1,0,1.
        do_reset();
        grant_q0.delete();
        for (int i = 0; i < 6; i++) begin
            e.port  = i % 2;
            e.hdr   = (i % 2 == 0) ? 32'h03000000 : 32'h03000800;
            e.rdata = (i % 2 == 0) ? 32'h69A53C5A : 32'h69A5345A;
            sb0.push_back(e);
        end
        base = acks_seen[0];
        set_req(0, 0, 1'b1, 24'h000000);
        set_req(0, 1, 1'b1, 24'h000800);
        wait_acks(0, base + 6, 2000, "contention acks");
        set_req(0, 0, 1'b0, 24'h000000);
        set_req(0, 1, 1'b0, 24'h000800);
        tick(10);
        check("contention grant count", 64'(grant_q0.size()), 64'd6);
        for (int i = 1; i < 6 && i < grant_q0.size(); i++)
            check($sformatf("grant spacing %0d", i), 64'(grant_q0[i] - grant_q0[i-1]), 64'd261);

        // Reset at SHIFT cycle 60 aborts the frame without an ack.
        set_req(0, 0, 1'b1, 24'h000104);
        for (int i = 0; i < 20 && bus0.ss !== 1'b0; i++) tick(1);
        check("abort grant seen", 64'(bus0.ss), 64'h0);
        g0 = acks_seen[0];
        tick(59);
        check("abort busy before", 64'(bus0.busy), 64'h1);
        reset = 1'b1;
        set_req(0, 0, 1'b0, 24'h000104);
        tick(1);
        check("abort ss",      64'(bus0.ss),      64'h1);
        check("abort spi_clk", 64'(bus0.spi_clk), 64'h0);
        check("abort busy",    64'(bus0.busy),    64'h0);
        check("abort mosi",    64'(bus0.mosi),    64'h0);
        reset = 1'b0;
        tick(300);
        check("abort no ack", 64'(acks_seen[0]), 64'(g0));
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
